microwave_timer_ctrl: RTL and testbench

Sequencing controller for the minutes:seconds countdown counter chain of the microwave timer. It collects four BCD keypad digits (MM:SS), loads them into the counters through their active-low parallel-load input, and generates the once-per-second count enable. It also handles start/pause/stop/door events and flags completion when the counter chain reports zero. It sits between the keypad/door inputs and the counter chain.

---
 rtl/microwave_timer_ctrl_if.sv | 26 ++
 rtl/microwave_timer_ctrl.sv | 170 +++++++++++++++++
 tb/tb_microwave_timer_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/microwave_timer_ctrl_if.sv
// Signal bundle between the microwave timer controller and its surroundings:
// keypad/door/start/stop events in, counter-chain control out.
interface microwave_timer_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        start;
  logic        stop;
  logic        door_closed;
  logic        timer_zero;
  logic [15:0] load_data;
  logic        load_n;
  logic        cnt_clear_n;
  logic        enab;
  logic        magnetron_on;
  logic        done;

  modport master (
    output key_valid, key_digit, start, stop, door_closed, timer_zero,
    input  load_data, load_n, cnt_clear_n, enab, magnetron_on, done
  );

  modport slave (
    input  key_valid, key_digit, start, stop, door_closed, timer_zero,
    output load_data, load_n, cnt_clear_n, enab, magnetron_on, done
  );
endinterface

// File: rtl/microwave_timer_ctrl.sv
// Sequencer for the MM:SS countdown chain: keypad entry, parallel load,
// one-second count enable, pause/resume/cancel and completion flag.
module microwave_timer_ctrl #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic                   clk,
  input  logic                   clear,
  microwave_timer_ctrl_if.slave  bus
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_LOAD    = 3'd2,
    S_RUNNING = 3'd3,
    S_PAUSED  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   load_data_q, load_data_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          first_q, first_d;
  logic          load_n_q, load_n_d;
  logic          cnt_clear_n_q, cnt_clear_n_d;
  logic          enab_q, enab_d;
  logic          magnetron_on_q, magnetron_on_d;
  logic          done_q, done_d;

  logic          key_ok_s;
  logic          start_ok_s;
  logic          zero_seen_s;
  logic          shift_s;
  logic          enter_idle_s;

  assign key_ok_s    = bus.key_valid && (bus.key_digit <= 4'd9);
  // S1 is the tens-of-seconds digit; anything above 5 is not a valid time.
  assign start_ok_s  = bus.start && bus.door_closed &&
                       (load_data_q != 16'h0000) && (load_data_q[7:4] <= 4'd5);
  assign zero_seen_s = bus.timer_zero && !first_q;

  // Next-state selection, honouring stop > door open > start > key.
  always_comb begin
    state_d = state_q;
    shift_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_ok_s) begin
          state_d = S_ENTRY;
          shift_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ENTRY: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (start_ok_s) begin
          state_d = S_LOAD;
        end else if (key_ok_s) begin
          shift_s = 1'b1;
        end else begin
          state_d = S_ENTRY;
        end
      end
      S_LOAD: begin
        state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (bus.stop || !bus.door_closed) begin
          state_d = S_PAUSED;
        end else if (zero_seen_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUNNING;
        end
      end
      S_PAUSED: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.start && bus.door_closed) begin
          state_d = S_RUNNING;
        end else begin
          state_d = S_PAUSED;
        end
      end
      S_DONE: begin
        if (bus.stop || bus.key_valid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and registered-output next values derived from the transition.
  always_comb begin
    enter_idle_s = (state_d == S_IDLE) && (state_q != S_IDLE);

    if (enter_idle_s) begin
      load_data_d = 16'h0000;
    end else if (shift_s) begin
      load_data_d = {load_data_q[11:0], bus.key_digit};
    end else begin
      load_data_d = load_data_q;
    end

    // The prescaler only advances on cycles that stay in RUNNING, so the
    // cycle that pauses does not consume part of the second.
    if (enter_idle_s || (state_q == S_LOAD)) begin
      presc_d = {PW{1'b0}};
    end else if ((state_q == S_RUNNING) && (state_d == S_RUNNING)) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = {PW{1'b0}};
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end

    enab_d         = (state_q == S_RUNNING) && (state_d == S_RUNNING) &&
                     (presc_q == PRESC_LAST);
    first_d        = (state_q == S_LOAD);
    load_n_d       = (state_d != S_LOAD);
    cnt_clear_n_d  = !enter_idle_s;
    magnetron_on_d = (state_d == S_RUNNING);
    done_d         = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q        <= S_IDLE;
      load_data_q    <= 16'h0000;
      presc_q        <= {PW{1'b0}};
      first_q        <= 1'b0;
      load_n_q       <= 1'b1;
      cnt_clear_n_q  <= 1'b1;
      enab_q         <= 1'b0;
      magnetron_on_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_data_q    <= load_data_d;
      presc_q        <= presc_d;
      first_q        <= first_d;
      load_n_q       <= load_n_d;
      cnt_clear_n_q  <= cnt_clear_n_d;
      enab_q         <= enab_d;
      magnetron_on_q <= magnetron_on_d;
      done_q         <= done_d;
    end
  end

  assign bus.load_data    = load_data_q;
  assign bus.load_n       = load_n_q;
  assign bus.cnt_clear_n  = cnt_clear_n_q;
  assign bus.enab         = enab_q;
  assign bus.magnetron_on = magnetron_on_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl with a behavioural counter chain
// that loads, clears and counts down from the controller's outputs.
module tb_microwave_timer_ctrl;

  localparam int TPS = 4;

  logic        clk = 1'b0;
  logic        clear;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt_q;

  microwave_timer_ctrl_if bus_if ();

  microwave_timer_ctrl #(.TICKS_PER_SEC(TPS)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Counter chain model: clear, parallel load, count-down on enab.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q <= 16'h0000;
    end else if (!bus_if.cnt_clear_n) begin
      cnt_q <= 16'h0000;
    end else if (!bus_if.load_n) begin
      cnt_q <= bus_if.load_data;
    end else if (bus_if.enab && (cnt_q != 16'h0000)) begin
      cnt_q <= cnt_q - 16'h0001;
    end
  end

  assign bus_if.timer_zero = (cnt_q == 16'h0000);

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    bus_if.key_valid = 1'b1;
    bus_if.key_digit = d;
    @(negedge clk);
    bus_if.key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus_if.stop = 1'b1;
    @(negedge clk);
    bus_if.stop = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_load_data"}, bus_if.load_data, 16'h0000);
    check_eq({tag, "_load_n"}, 16'(bus_if.load_n), 16'h0001);
    check_eq({tag, "_cnt_clear_n"}, 16'(bus_if.cnt_clear_n), 16'h0001);
    check_eq({tag, "_enab"}, 16'(bus_if.enab), 16'h0000);
    check_eq({tag, "_magnetron"}, 16'(bus_if.magnetron_on), 16'h0000);
    check_eq({tag, "_done"}, 16'(bus_if.done), 16'h0000);
  endtask

  initial begin
    clear              = 1'b0;
    bus_if.key_valid   = 1'b0;
    bus_if.key_digit   = 4'd0;
    bus_if.start       = 1'b0;
    bus_if.stop        = 1'b0;
    bus_if.door_closed = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst");
    clear = 1'b1;
    tick();
    check_reset_outputs("post_rst");

    // Entry 12:30, start, then pause and cancel.
    press(4'd1); press(4'd2); press(4'd3); press(4'd0);
    check_eq("entry_1230", bus_if.load_data, 16'h1230);
    pulse_start();
    check_eq("a_load_n_low", 16'(bus_if.load_n), 16'h0000);
    check_eq("a_mag_in_load", 16'(bus_if.magnetron_on), 16'h0000);
    check_eq("a_data_in_load", bus_if.load_data, 16'h1230);
    tick();
    check_eq("a_load_n_high", 16'(bus_if.load_n), 16'h0001);
    check_eq("a_mag_running", 16'(bus_if.magnetron_on), 16'h0001);
    pulse_stop();
    check_eq("a_mag_paused", 16'(bus_if.magnetron_on), 16'h0000);
    pulse_stop();
    check_eq("a_clear_pulse", 16'(bus_if.cnt_clear_n), 16'h0000);
    check_eq("a_data_zeroed", bus_if.load_data, 16'h0000);
    tick();
    check_eq("a_clear_release", 16'(bus_if.cnt_clear_n), 16'h0001);

    // Entry 00:02 runs to completion: enab at RUNNING cycles 4 and 8.
    press(4'd0); press(4'd0); press(4'd0); press(4'd2);
    check_eq("entry_0002", bus_if.load_data, 16'h0002);
    pulse_start();
    check_eq("b_load_n_low", 16'(bus_if.load_n), 16'h0000);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq($sformatf("b_enab_k%0d", k), 16'(bus_if.enab),
               ((k == 4) || (k == 8)) ? 16'h0001 : 16'h0000);
      check_eq($sformatf("b_mag_k%0d", k), 16'(bus_if.magnetron_on), 16'h0001);
    end
    tick();
    check_eq("b_done", 16'(bus_if.done), 16'h0001);
    check_eq("b_mag_off", 16'(bus_if.magnetron_on), 16'h0000);
    check_eq("b_enab_done", 16'(bus_if.enab), 16'h0000);
    press(4'd7);
    check_eq("b_done_cleared", 16'(bus_if.done), 16'h0000);
    check_eq("b_clear_pulse", 16'(bus_if.cnt_clear_n), 16'h0000);
    check_eq("b_data_zeroed", bus_if.load_data, 16'h0000);
    tick();

    // Door opens after one counted cycle; resume completes the second.
    press(4'd0); press(4'd0); press(4'd0); press(4'd5);
    pulse_start();
    tick();
    tick();
    bus_if.door_closed = 1'b0;
    for (int p = 0; p < 4; p++) begin
      tick();
      check_eq($sformatf("c_pause_enab_%0d", p), 16'(bus_if.enab), 16'h0000);
      check_eq($sformatf("c_pause_mag_%0d", p), 16'(bus_if.magnetron_on), 16'h0000);
    end
    pulse_start();
    check_eq("c_start_door_open", 16'(bus_if.magnetron_on), 16'h0000);
    bus_if.door_closed = 1'b1;
    pulse_start();
    check_eq("c_resume_mag", 16'(bus_if.magnetron_on), 16'h0001);
    check_eq("c_resume_no_load", 16'(bus_if.load_n), 16'h0001);
    check_eq("c_enab_r0", 16'(bus_if.enab), 16'h0000);
    tick();
    check_eq("c_enab_r1", 16'(bus_if.enab), 16'h0000);
    tick();
    check_eq("c_enab_r2", 16'(bus_if.enab), 16'h0000);
    tick();
    check_eq("c_enab_r3", 16'(bus_if.enab), 16'h0001);
    pulse_stop();
    pulse_stop();
    check_eq("c_clear_pulse", 16'(bus_if.cnt_clear_n), 16'h0000);
    check_eq("c_data_zeroed", bus_if.load_data, 16'h0000);
    tick();

    // Invalid starts, digit overflow, stop+start collision.
    press(4'd0); press(4'd0); press(4'd7); press(4'd0);
    check_eq("entry_0070", bus_if.load_data, 16'h0070);
    pulse_start();
    check_eq("d_s1_7_no_load", 16'(bus_if.load_n), 16'h0001);
    press(4'd1);
    check_eq("d_still_entry", bus_if.load_data, 16'h0701);
    press(4'd12);
    check_eq("d_digit_gt9", bus_if.load_data, 16'h0701);
    pulse_stop();
    check_eq("d_stop_entry", bus_if.load_data, 16'h0000);
    tick();
    press(4'd0);
    pulse_start();
    check_eq("d_zero_no_load", 16'(bus_if.load_n), 16'h0001);
    for (int d = 1; d <= 5; d++) begin
      press(4'(d));
    end
    check_eq("entry_2345", bus_if.load_data, 16'h2345);
    bus_if.stop  = 1'b1;
    bus_if.start = 1'b1;
    tick();
    bus_if.stop  = 1'b0;
    bus_if.start = 1'b0;
    check_eq("d_collide_load_n", 16'(bus_if.load_n), 16'h0001);
    check_eq("d_collide_clear", 16'(bus_if.cnt_clear_n), 16'h0000);
    check_eq("d_collide_data", bus_if.load_data, 16'h0000);
    tick();

    // Asynchronous clear in the middle of an enab pulse.
    press(4'd1); press(4'd0); press(4'd0); press(4'd0);
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    check_eq("e_enab_before", 16'(bus_if.enab), 16'h0001);
    clear = 1'b0;
    #1;
    check_reset_outputs("e_async");
    tick();
    check_reset_outputs("e_held");
    clear = 1'b1;
    tick();
    press(4'd4);
    check_eq("e_key_after", bus_if.load_data, 16'h0004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
